glitch_sweep_controller: RTL and testbench

//  Parametrised successor to the central glitch controller: runs a full, autonomous delay sweep.
//  For each delay point it performs ATTEMPTS glitch attempts. Each attempt is:

---
 rtl/glitch_sweep_controller_if.sv | 74 +++++++
 rtl/glitch_sweep_controller.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_glitch_sweep_controller.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_sweep_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : glitch_sweep_controller_if
// Purpose  : Bundles the host configuration, detector handshakes and
//            target-control signals of the glitch sweep controller.
// Modports : master - the sweep controller (drives delay/arm/reset/result)
//            slave  - the surrounding blocks / host (drive config/detectors)
// Options  : GLITCH_WIDTH_SWEEP_EN adds width_start/width_end/width_step,
//            glitch_width, set_width and result_width.
// Revision : 1.0 - initial release
// ============================================================================
interface glitch_sweep_controller_if #(
  parameter int DELAY_W = 32,
  parameter int ATT_W   = 8
);
  // Host / configuration
  logic               start;
  logic               abort;
  logic [DELAY_W-1:0] delay_start;
  logic [DELAY_W-1:0] delay_end;
  logic [DELAY_W-1:0] delay_step;
  logic [ATT_W-1:0]   attempts;
  // Detectors / target
  logic               trigger;
  logic               success;
  logic               target_alive;
  // Controller outputs
  logic [DELAY_W-1:0] delay;
  logic               set_delay;
  logic               trigger_arm;
  logic               success_arm;
  logic               target_soft_reset;
  logic               target_hard_reset;
  logic               busy;
  logic               done;
  logic               error;
  logic               result_valid;
  logic [DELAY_W-1:0] result_delay;
  logic               result_success;
  logic               result_timeout;
`ifdef GLITCH_WIDTH_SWEEP_EN
  logic [DELAY_W-1:0] width_start;
  logic [DELAY_W-1:0] width_end;
  logic [DELAY_W-1:0] width_step;
  logic [DELAY_W-1:0] glitch_width;
  logic               set_width;
  logic [DELAY_W-1:0] result_width;
`endif

  modport master (
`ifdef GLITCH_WIDTH_SWEEP_EN
    input  width_start, width_end, width_step,
    output glitch_width, set_width, result_width,
`endif
    input  start, abort, delay_start, delay_end, delay_step, attempts,
    input  trigger, success, target_alive,
    output delay, set_delay, trigger_arm, success_arm,
    output target_soft_reset, target_hard_reset, busy, done, error,
    output result_valid, result_delay, result_success, result_timeout
  );

  modport slave (
`ifdef GLITCH_WIDTH_SWEEP_EN
    output width_start, width_end, width_step,
    input  glitch_width, set_width, result_width,
`endif
    output start, abort, delay_start, delay_end, delay_step, attempts,
    output trigger, success, target_alive,
    input  delay, set_delay, trigger_arm, success_arm,
    input  target_soft_reset, target_hard_reset, busy, done, error,
    input  result_valid, result_delay, result_success, result_timeout
  );
endinterface
`default_nettype wire

// File: rtl/glitch_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : glitch_sweep_controller
// Purpose  : Autonomous glitch delay sweep. For every delay point it runs
//            ATTEMPTS attempts of: reset target -> program delay -> arm
//            trigger -> wait trigger -> success window -> report result.
// Ports    : clk  - system clock
//            rst  - synchronous, active-low reset
//            bus  - glitch_sweep_controller_if.master (config, detector
//                   handshakes, target resets, per-attempt results)
// Options  : GLITCH_WIDTH_SWEEP_EN adds an inner glitch-width sweep loop.
// Revision : 1.0 - initial release
// ============================================================================
module glitch_sweep_controller #(
  parameter int DELAY_W      = 32,
  parameter int ATT_W        = 8,
  parameter int RST_PULSE    = 16,
  parameter int BOOT_TIMEOUT = 4096,
  parameter int TRIG_TIMEOUT = 65536,
  parameter int SUCCESS_WIN  = 1024
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  glitch_sweep_controller_if.master   bus
);

  localparam int MAX_A   = (RST_PULSE > BOOT_TIMEOUT) ? RST_PULSE : BOOT_TIMEOUT;
  localparam int MAX_B   = (TRIG_TIMEOUT > SUCCESS_WIN) ? TRIG_TIMEOUT : SUCCESS_WIN;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(SUCCESS_WIN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SOFT_RST, S_BOOT_WAIT, S_HARD_RST, S_LOAD, S_ARM,
    S_WINDOW, S_REPORT, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [ATT_W-1:0]   attempts_q, attempts_d;
  logic [DELAY_W-1:0] point_q, point_d;
  logic [DELAY_W-1:0] end_q, end_d;
  logic [DELAY_W-1:0] step_q, step_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               hard_tried_q, hard_tried_d;
  logic               succ_q, succ_d;
  logic               timeout_q, timeout_d;
  logic               error_q, error_d;

  // Point advance uses one extra bit so a carry ends the sweep instead of
  // wrapping back to a small delay.
  logic [DELAY_W:0]   w_next_point;
  logic               w_point_more;
  logic [ATT_W:0]     w_att_inc;
  logic               w_last_att;
  logic               w_empty;

  assign w_next_point = {1'b0, point_q} + {1'b0, step_q};
  assign w_point_more = (step_q != '0) && !w_next_point[DELAY_W] &&
                        (w_next_point[DELAY_W-1:0] <= end_q);
  assign w_att_inc    = {1'b0, att_q} + (ATT_W+1)'(1);
  assign w_last_att   = (w_att_inc >= {1'b0, attempts_q});

`ifdef GLITCH_WIDTH_SWEEP_EN
  logic [DELAY_W-1:0] wpoint_q, wpoint_d;
  logic [DELAY_W-1:0] wstart_q, wstart_d;
  logic [DELAY_W-1:0] wend_q, wend_d;
  logic [DELAY_W-1:0] wstep_q, wstep_d;
  logic [DELAY_W-1:0] width_q, width_d;
  logic [DELAY_W:0]   w_next_width;
  logic               w_width_more;

  assign w_next_width = {1'b0, wpoint_q} + {1'b0, wstep_q};
  assign w_width_more = (wstep_q != '0) && !w_next_width[DELAY_W] &&
                        (w_next_width[DELAY_W-1:0] <= wend_q);
  assign w_empty      = (bus.delay_start > bus.delay_end) ||
                        (bus.width_start > bus.width_end);
`else
  assign w_empty      = (bus.delay_start > bus.delay_end);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      att_q        <= '0;
      attempts_q   <= '0;
      point_q      <= '0;
      end_q        <= '0;
      step_q       <= '0;
      delay_q      <= '0;
      hard_tried_q <= 1'b0;
      succ_q       <= 1'b0;
      timeout_q    <= 1'b0;
      error_q      <= 1'b0;
`ifdef GLITCH_WIDTH_SWEEP_EN
      wpoint_q     <= '0;
      wstart_q     <= '0;
      wend_q       <= '0;
      wstep_q      <= '0;
      width_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      att_q        <= att_d;
      attempts_q   <= attempts_d;
      point_q      <= point_d;
      end_q        <= end_d;
      step_q       <= step_d;
      delay_q      <= delay_d;
      hard_tried_q <= hard_tried_d;
      succ_q       <= succ_d;
      timeout_q    <= timeout_d;
      error_q      <= error_d;
`ifdef GLITCH_WIDTH_SWEEP_EN
      wpoint_q     <= wpoint_d;
      wstart_q     <= wstart_d;
      wend_q       <= wend_d;
      wstep_q      <= wstep_d;
      width_q      <= width_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    att_d        = att_q;
    attempts_d   = attempts_q;
    point_d      = point_q;
    end_d        = end_q;
    step_d       = step_q;
    delay_d      = delay_q;
    hard_tried_d = hard_tried_q;
    succ_d       = succ_q;
    timeout_d    = timeout_q;
    error_d      = error_q;
`ifdef GLITCH_WIDTH_SWEEP_EN
    wpoint_d     = wpoint_q;
    wstart_d     = wstart_q;
    wend_d       = wend_q;
    wstep_d      = wstep_q;
    width_d      = width_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          point_d      = bus.delay_start;
          end_d        = bus.delay_end;
          step_d       = bus.delay_step;
          attempts_d   = (bus.attempts == '0) ? ATT_W'(1) : bus.attempts;
          att_d        = '0;
          hard_tried_d = 1'b0;
          error_d      = 1'b0;
`ifdef GLITCH_WIDTH_SWEEP_EN
          wpoint_d     = bus.width_start;
          wstart_d     = bus.width_start;
          wend_d       = bus.width_end;
          wstep_d      = bus.width_step;
`endif
          // An empty range still completes the handshake with a done pulse.
          state_d      = w_empty ? S_DONE : S_SOFT_RST;
        end
      end
      S_SOFT_RST: begin
        if (cnt_q == RST_LAST) state_d = S_BOOT_WAIT;
      end
      S_BOOT_WAIT: begin
        if (bus.target_alive) begin
          state_d = S_LOAD;
          delay_d = point_q;
`ifdef GLITCH_WIDTH_SWEEP_EN
          width_d = wpoint_q;
`endif
        end else if (cnt_q == BOOT_LAST) begin
          if (hard_tried_q) begin
            state_d = S_FAIL;
            error_d = 1'b1;
          end else begin
            state_d      = S_HARD_RST;
            hard_tried_d = 1'b1;
          end
        end
      end
      S_HARD_RST: begin
        if (cnt_q == RST_LAST) state_d = S_BOOT_WAIT;
      end
      S_LOAD: begin
        succ_d    = 1'b0;
        timeout_d = 1'b0;
        state_d   = S_ARM;
      end
      S_ARM: begin
        if (bus.trigger) begin
          state_d = S_WINDOW;
        end else if (cnt_q == TRIG_LAST) begin
          state_d   = S_REPORT;
          timeout_d = 1'b1;
        end
      end
      S_WINDOW: begin
        if (bus.success) succ_d = 1'b1;
        if (cnt_q == WIN_LAST) state_d = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        hard_tried_d = 1'b0;
        if (!w_last_att) begin
          att_d   = w_att_inc[ATT_W-1:0];
          state_d = S_SOFT_RST;
        end else begin
          att_d = '0;
`ifdef GLITCH_WIDTH_SWEEP_EN
          if (w_width_more) begin
            wpoint_d = w_next_width[DELAY_W-1:0];
            state_d  = S_SOFT_RST;
          end else if (w_point_more) begin
            wpoint_d = wstart_q;
            point_d  = w_next_point[DELAY_W-1:0];
            state_d  = S_SOFT_RST;
          end else begin
            state_d  = S_DONE;
          end
`else
          if (w_point_more) begin
            point_d = w_next_point[DELAY_W-1:0];
            state_d = S_SOFT_RST;
          end else begin
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the current state decided this cycle; the
    // terminal states already pulse done, so they are left alone.
    if (bus.abort && (state_q != S_IDLE) && (state_q != S_DONE) &&
        (state_q != S_FAIL)) begin
      state_d = S_DONE;
      error_d = error_q;
      delay_d = delay_q;
`ifdef GLITCH_WIDTH_SWEEP_EN
      width_d = width_q;
`endif
    end

    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.delay             = delay_q;
  assign bus.set_delay         = (state_q == S_LOAD);
  assign bus.trigger_arm       = (state_q == S_ARM);
  assign bus.success_arm       = (state_q == S_WINDOW);
  assign bus.target_soft_reset = (state_q == S_SOFT_RST);
  assign bus.target_hard_reset = (state_q == S_HARD_RST);
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = (state_q == S_DONE) || (state_q == S_FAIL);
  assign bus.error             = error_q;
  assign bus.result_valid      = (state_q == S_REPORT);
  assign bus.result_delay      = (state_q == S_REPORT) ? delay_q : '0;
  assign bus.result_success    = (state_q == S_REPORT) && succ_q;
  assign bus.result_timeout    = (state_q == S_REPORT) && timeout_q;
`ifdef GLITCH_WIDTH_SWEEP_EN
  assign bus.glitch_width      = width_q;
  assign bus.set_width         = (state_q == S_LOAD);
  assign bus.result_width      = (state_q == S_REPORT) ? width_q : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitch_sweep_controller
// Purpose  : Self-checking bench for glitch_sweep_controller (default build,
//            GLITCH_WIDTH_SWEEP_EN undefined). A behavioural target, trigger
//            and success detector respond to the controller; expected result
//            lists come from the sweep rules computed directly from config.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_sweep_controller;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RP = 4;
  localparam int BT = 40;
  localparam int TT = 60;
  localparam int SW = 16;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        t;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  glitch_sweep_controller_if #(.DELAY_W(DW), .ATT_W(AW)) bus ();

  glitch_sweep_controller #(
    .DELAY_W(DW), .ATT_W(AW), .RST_PULSE(RP), .BOOT_TIMEOUT(BT),
    .TRIG_TIMEOUT(TT), .SUCCESS_WIN(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Environment configuration
  int          alive_lat_v = -1;
  int          trig_lat_v  = -1;
  logic [31:0] plan_v      = '0;
  bit          aborting    = 0;

  // Monitor state
  res_t got_q[$];
  int   done_cnt, done_cyc, soft_cyc, hard_cyc, setd_cnt;
  int   win_idx, win_len, arm_cnt, arm_start_cyc, since_rst;
  bit   busy_at_done;
  logic prev_sarm = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0; done_cyc = 0; soft_cyc = 0; hard_cyc = 0; setd_cnt = 0;
    win_idx = 0; busy_at_done = 0; aborting = 0;
  endtask

  // Behavioural target / detectors plus result monitor, sampled 1 ns after
  // each rising edge.
  initial begin
    bus.trigger = 1'b0; bus.success = 1'b0; bus.target_alive = 1'b0;
    arm_cnt = 0; win_len = 0; since_rst = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.result_valid) begin
        got_q.push_back('{d: bus.result_delay, s: bus.result_success,
                          t: bus.result_timeout});
        if (bus.result_timeout)
          check_val("timeout_latency", 64'(cyc - arm_start_cyc), 64'(TT));
      end
      if (bus.done) begin
        done_cnt++; done_cyc = cyc; busy_at_done = bus.busy;
      end
      if (bus.target_soft_reset) soft_cyc++;
      if (bus.target_hard_reset) hard_cyc++;
      if (bus.set_delay) setd_cnt++;
      // Trigger detector: fires trig_lat_v cycles into the arm period.
      if (bus.trigger_arm) begin
        if (arm_cnt == 0) arm_start_cyc = cyc;
        arm_cnt++;
      end else begin
        arm_cnt = 0;
      end
      bus.trigger = bus.trigger_arm && (trig_lat_v >= 0) && (arm_cnt == trig_lat_v);
      // Success detector: one pulse 3 cycles into windows selected by plan_v.
      if (bus.success_arm) begin
        if (!prev_sarm) win_len = 0;
        win_len++;
        bus.success = (win_len == 3) && (win_idx < 32) && plan_v[win_idx];
      end else begin
        bus.success = 1'b0;
        if (prev_sarm) begin
          if (!aborting) check_val("window_len", 64'(win_len), 64'(SW));
          win_idx++;
        end
      end
      prev_sarm = bus.success_arm;
      // Target: boots alive_lat_v cycles after its reset is released.
      if (bus.target_soft_reset || bus.target_hard_reset) begin
        since_rst = 0;
        bus.target_alive = 1'b0;
      end else begin
        since_rst++;
        bus.target_alive = (alive_lat_v >= 0) && (since_rst >= alive_lat_v);
      end
    end
  end

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input logic [7:0] att,
                           input int alat, input int tlat,
                           input logic [31:0] plan, input bit exp_fail,
                           input string tag);
    res_t        exp_q[$];
    logic [32:0] p, nx;
    int          n_att, k, start_cyc;
    n_att = (att == 0) ? 1 : int'(att);
    // Reference: enumerate points start, start+step, ... while <= end with
    // no wrap; step 0 gives one point; every point repeated n_att times.
    if (!exp_fail && s <= e) begin
      p = {1'b0, s};
      forever begin
        for (int a = 0; a < n_att; a++) begin
          k = exp_q.size();
          exp_q.push_back('{d: p[31:0], s: (tlat >= 0) && plan[k], t: (tlat < 0)});
        end
        nx = p + {1'b0, st};
        if (st == 0 || nx > {1'b0, e}) break;
        p = nx;
      end
    end

    @(negedge clk);
    alive_lat_v = alat; trig_lat_v = tlat; plan_v = plan;
    clear_mon();
    bus.delay_start = s; bus.delay_end = e; bus.delay_step = st;
    bus.attempts = att; bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    // Later config changes must not influence the running sweep.
    bus.delay_start = $urandom; bus.delay_end = $urandom;
    bus.delay_step = $urandom; bus.attempts = 8'($urandom);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
    check_val({tag, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    @(negedge clk); @(negedge clk);
    check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
    check_val({tag, "_busy_at_done"}, 64'(busy_at_done), 64'(1));
    check_val({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
    check_val({tag, "_error"}, 64'(bus.error), 64'(exp_fail));
    check_val({tag, "_n_results"}, 64'(got_q.size()), 64'(exp_q.size()));
    check_val({tag, "_n_set_delay"}, 64'(setd_cnt), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val({tag, "_res_delay"}, 64'(got_q[i].d), 64'(exp_q[i].d));
      check_val({tag, "_res_success"}, 64'(got_q[i].s), 64'(exp_q[i].s));
      check_val({tag, "_res_timeout"}, 64'(got_q[i].t), 64'(exp_q[i].t));
    end
    if (exp_fail) begin
      check_val({tag, "_soft_cycles"}, 64'(soft_cyc), 64'(RP));
      check_val({tag, "_hard_cycles"}, 64'(hard_cyc), 64'(RP));
      check_val({tag, "_done_latency"}, 64'(done_cyc - start_cyc), 64'(2*RP + 2*BT + 1));
    end else begin
      check_val({tag, "_soft_cycles"}, 64'(soft_cyc), 64'(RP * exp_q.size()));
      check_val({tag, "_hard_cycles"}, 64'(hard_cyc), 64'(0));
      if (exp_q.size() == 0)
        check_val({tag, "_done_latency"}, 64'(done_cyc - start_cyc), 64'(1));
    end
  endtask

  initial begin
    int          npts, alat, tlat;
    logic [31:0] s, e, st;
    logic [7:0]  att;

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.delay_start = '0; bus.delay_end = '0; bus.delay_step = '0;
    bus.attempts = '0;
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("reset_ctrl_outputs",
              64'({bus.set_delay, bus.trigger_arm, bus.success_arm,
                   bus.target_soft_reset, bus.target_hard_reset, bus.busy,
                   bus.done, bus.error, bus.result_valid, bus.result_success,
                   bus.result_timeout}), 64'(0));
    check_val("reset_delay", 64'(bus.delay), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: basic sweep, success only on the 2nd attempt
    run_sweep(32'd10, 32'd30, 32'd10, 8'd2, 5, 20, 32'b10, 1'b0, "basic");
    // Trigger never comes
    run_sweep(32'd0, 32'd2, 32'd1, 8'd1, 5, -1, 32'h0, 1'b0, "trig_tmo");
    // Overflow: only one point fits
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 8'd1, 3, 5, 32'h1, 1'b0, "overflow");
    // Empty range
    run_sweep(32'd5, 32'd4, 32'd1, 8'd1, 3, 5, 32'h0, 1'b0, "empty");
    // Zero step, zero attempts treated as one
    run_sweep(32'd77, 32'd90, 32'd0, 8'd0, 2, 3, 32'h1, 1'b0, "zero_step");
    // Boot failure
    run_sweep(32'd1, 32'd3, 32'd1, 8'd1, -1, 5, 32'h0, 1'b1, "boot_fail");
    repeat (5) @(negedge clk);
    check_val("error_sticky", 64'(bus.error), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    check_val("error_cleared_by_reset", 64'(bus.error), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // start and abort together while idle: nothing starts
    clear_mon();
    alive_lat_v = 2; trig_lat_v = 4;
    bus.delay_start = 32'd1; bus.delay_end = 32'd1; bus.delay_step = 32'd1;
    bus.attempts = 8'd1;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check_val("start_abort_idle_busy", 64'(bus.busy), 64'(0));
    repeat (RP + 3) @(negedge clk);
    check_val("start_abort_idle_resets", 64'(soft_cyc + done_cnt), 64'(0));

    // Abort mid-window
    clear_mon();
    alive_lat_v = 2; trig_lat_v = 4; plan_v = '0;
    bus.delay_start = 32'd100; bus.delay_end = 32'd200; bus.delay_step = 32'd50;
    bus.attempts = 8'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 500 && !bus.success_arm; i++) @(negedge clk);
    check_val("abort_window_reached", 64'(bus.success_arm), 64'(1));
    repeat (3) @(negedge clk);
    aborting = 1; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_val("abort_arm_outputs",
              64'({bus.success_arm, bus.trigger_arm, bus.target_soft_reset,
                   bus.target_hard_reset}), 64'(0));
    check_val("abort_done", 64'(bus.done), 64'(1));
    @(negedge clk);
    check_val("abort_busy_after", 64'(bus.busy), 64'(0));
    check_val("abort_no_result", 64'(got_q.size()), 64'(0));
    run_sweep(32'd100, 32'd200, 32'd50, 8'd1, 2, 4, 32'b101, 1'b0, "after_abort");

    // Reset in the middle of a sweep
    clear_mon();
    alive_lat_v = 2; trig_lat_v = -1;
    bus.delay_start = 32'd7; bus.delay_end = 32'd7; bus.delay_step = 32'd1;
    bus.attempts = 8'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 500 && !bus.trigger_arm; i++) @(negedge clk);
    check_val("midrst_armed", 64'(bus.trigger_arm), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_outputs",
              64'({bus.trigger_arm, bus.busy, bus.error, bus.done,
                   bus.target_soft_reset, bus.result_valid}), 64'(0));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_stays_idle", 64'({bus.busy, got_q.size() != 0}), 64'(0));

    // Randomised sweeps
    for (int r = 0; r < 8; r++) begin
      s    = 32'($urandom_range(0, 1000));
      npts = $urandom_range(1, 4);
      st   = 32'($urandom_range(0, 9));
      e    = s + 32'(npts - 1) * st +
             ((st != 0) ? 32'($urandom_range(0, int'(st) - 1)) : 32'($urandom_range(0, 5)));
      att  = 8'($urandom_range(0, 3));
      alat = $urandom_range(1, 10);
      tlat = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 20);
      run_sweep(s, e, st, att, alat, tlat, $urandom, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
